// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-ported Data Memory between the CPU data port
// and the I/O DMA requester. The CPU is favoured; a starvation counter forces DMA through.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu_cs/rd/wr, cpu_addr, cpu_wdata -> cpu_rdata, cpu_stall
//   io_req, io_wr, io_addr, io_wdata  -> io_gnt, io_done, io_rdata
//   mem_cs/rd/wr, mem_addr, mem_wdata <- mem_rdata
module dm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        io_req,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic        io_gnt,
  output logic        io_done,
  output logic [31:0] io_rdata,
  output logic        mem_cs,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       io_live;
  logic       grant;
  logic       starved;

  // A request is ignored during its own done cycle,
  // so every DMA access costs at least two cycles.
  assign io_live = io_req & ~io_done;
  assign starved = (starve_cnt == LIMIT);
  assign grant   = io_live & (~cpu_cs | starved);

  assign io_gnt    = reset & grant;
  assign cpu_stall = reset & cpu_cs & grant;

  always_comb begin
    mem_cs    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (grant) begin
        mem_cs    = 1'b1;
        mem_rd    = ~io_wr;
        mem_wr    = io_wr;
        mem_addr  = io_addr;
        mem_wdata = io_wdata;
      end else begin
        // rd & wr together is passed through untouched
        mem_cs    = cpu_cs;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  assign cpu_rdata = (reset & ~grant) ? mem_rdata : 32'h0;

  always_comb begin
    starve_nxt = starve_cnt;
    unique case (1'b1)
      grant:
        starve_nxt = '0;
      io_live & cpu_cs & ~starved:
        starve_nxt = starve_cnt + 4'd1;
      default:
        starve_nxt = starve_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      io_done    <= 1'b0;
      io_rdata   <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      // grant already excludes the done cycle,
      // so the pulse is always one cycle wide
      io_done    <= grant;
      if (grant & ~io_wr) begin
        io_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vectors for dm_arbiter with a
// scoreboard of expected DMA completions.
module tb_dm_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        cpu_cs, cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        io_req, io_wr;
  logic [31:0] io_addr, io_wdata;
  logic        io_gnt, io_done;
  logic [31:0] io_rdata;
  logic        mem_cs, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_cpu_cs, b_cpu_rd, b_cpu_wr;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_cpu_stall;
  logic        b_io_req, b_io_wr;
  logic [31:0] b_io_addr, b_io_wdata;
  logic        b_io_gnt, b_io_done;
  logic [31:0] b_io_rdata;
  logic        b_mem_cs, b_mem_rd, b_mem_wr;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  dm_arbiter #(.STARVE_LIMIT(3)) u_a (
    .clk(clk), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_wr(io_wr),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_done(io_done), .io_rdata(io_rdata),
    .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.STARVE_LIMIT(0)) u_b (
    .clk(clk), .reset(reset),
    .cpu_cs(b_cpu_cs), .cpu_rd(b_cpu_rd), .cpu_wr(b_cpu_wr),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .io_req(b_io_req), .io_wr(b_io_wr),
    .io_addr(b_io_addr), .io_wdata(b_io_wdata),
    .io_gnt(b_io_gnt), .io_done(b_io_done), .io_rdata(b_io_rdata),
    .mem_cs(b_mem_cs), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Data Memory models; reset reloads the preset contents
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= '0;
      mem_a[8]  <= 32'h1234_5678;
      mem_a[9]  <= 32'hA5A5_0001;
      mem_a[10] <= 32'h0BAD_F00D;
    end else if (mem_cs & mem_wr) begin
      mem_a[mem_addr[7:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= '0;
    end else if (b_mem_cs & b_mem_wr) begin
      mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
    end
  end

  assign mem_rdata   = (mem_cs & mem_rd) ? mem_a[mem_addr[7:2]] : '0;
  assign b_mem_rdata = (b_mem_cs & b_mem_rd) ? mem_b[b_mem_addr[7:2]] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [31:0] d);
    exp_t e;
    e.cyc   = c;
    e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic idle;
    cpu_cs = 0; cpu_rd = 0; cpu_wr = 0;
    cpu_addr = '0; cpu_wdata = '0;
    io_req = 0; io_wr = 0; io_addr = '0; io_wdata = '0;
    b_cpu_cs = 0; b_cpu_rd = 0; b_cpu_wr = 0;
    b_cpu_addr = '0; b_cpu_wdata = '0;
    b_io_req = 0; b_io_wr = 0; b_io_addr = '0; b_io_wdata = '0;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // completion monitor for instance A
  always @(negedge clk) begin
    if (io_done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL io_done_unexpected: got 1 expected 0 at cycle %0d",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("io_done_cycle", cyc, e.cyc);
        chk("io_rdata", io_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] bb [3];

  initial begin
    bb[0] = 32'h1234_5678;
    bb[1] = 32'hA5A5_0001;
    bb[2] = 32'h0BAD_F00D;

    // reset with active requests
    reset = 0;
    idle();
    cpu_cs = 1; cpu_wr = 1; io_req = 1;
    repeat (2) smp();
    chk("rst_io_gnt", io_gnt, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_io_done", io_done, 0);
    chk("rst_io_rdata", io_rdata, 0);

    nxt(); idle(); reset = 1;

    // CPU only
    nxt(); idle();
    cpu_cs = 1; cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    smp();
    chk("cpu_wr_stall", cpu_stall, 0);
    chk("cpu_wr_mem_wr", mem_wr, 1);
    chk("cpu_wr_addr", mem_addr, 32'h10);
    chk("cpu_wr_data", mem_wdata, 32'hDEADBEEF);
    nxt(); idle();
    cpu_cs = 1; cpu_rd = 1; cpu_addr = 32'h10;
    smp();
    chk("cpu_rd_stall", cpu_stall, 0);
    chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
    nxt(); idle();
    cpu_cs = 1; cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h80; cpu_wdata = 5;
    smp();
    chk("cpu_rdwr_mem_rd", mem_rd, 1);
    chk("cpu_rdwr_mem_wr", mem_wr, 1);

    // DMA only
    nxt(); idle();
    io_req = 1; io_addr = 32'h20;
    push(cyc + 1, 32'h1234_5678);
    smp();
    chk("dma_gnt", io_gnt, 1);
    chk("dma_mem_rd", mem_rd, 1);
    chk("dma_mem_addr", mem_addr, 32'h20);
    chk("dma_stall", cpu_stall, 0);
    nxt();
    smp();
    chk("dma_done_gnt", io_gnt, 0);
    nxt(); idle();
    smp();

    // starvation, limit 3
    nxt(); idle();
    cpu_cs = 1; cpu_rd = 1; cpu_addr = 32'h10;
    io_req = 1; io_addr = 32'h20;
    push(cyc + 4, 32'h1234_5678);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        nxt();
        io_req = (k <= 4);
      end
      smp();
      chk("starve_gnt", io_gnt, (k == 3) ? 1 : 0);
      chk("starve_stall", cpu_stall, (k == 3) ? 1 : 0);
      if (k == 3) chk("starve_stall_rdata", cpu_rdata, 0);
      if (k == 4) chk("starve_cpu_resume", cpu_rdata, 32'hDEADBEEF);
    end
    nxt(); idle();
    smp();

    // back-to-back DMA reads
    for (int k = 0; k < 7; k++) begin
      nxt(); idle();
      io_req = (k < 6);
      io_addr = 32'h20 + 32'(4 * (k / 2));
      if (k < 6 && (k % 2) == 0) push(cyc + 1, bb[k / 2]);
      smp();
      chk("b2b_gnt", io_gnt, (k < 6 && (k % 2) == 0) ? 1 : 0);
    end

    // simultaneous writes, limit 0
    nxt(); idle();
    b_cpu_cs = 1; b_cpu_wr = 1; b_cpu_addr = 32'h40; b_cpu_wdata = 1;
    b_io_req = 1; b_io_wr = 1; b_io_addr = 32'h44; b_io_wdata = 2;
    smp();
    chk("l0_gnt", b_io_gnt, 1);
    chk("l0_stall", b_cpu_stall, 1);
    chk("l0_dma_addr", b_mem_addr, 32'h44);
    chk("l0_dma_data", b_mem_wdata, 2);
    chk("l0_dma_wr", b_mem_wr, 1);
    chk("l0_dma_rd", b_mem_rd, 0);
    chk("l0_stall_rdata", b_cpu_rdata, 0);
    nxt();
    smp();
    chk("l0_done", b_io_done, 1);
    chk("l0_done_gnt", b_io_gnt, 0);
    chk("l0_cpu_stall", b_cpu_stall, 0);
    chk("l0_cpu_addr", b_mem_addr, 32'h40);
    chk("l0_cpu_data", b_mem_wdata, 1);
    chk("l0_wr_rdata_hold", b_io_rdata, 0);
    nxt(); idle();
    smp();
    chk("l0_mem40", mem_b[16], 1);
    chk("l0_mem44", mem_b[17], 2);

    // reset in the middle of a granted DMA access
    nxt(); idle();
    cpu_cs = 1; cpu_rd = 1; cpu_addr = 32'h10;
    io_req = 1; io_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) nxt();
      smp();
    end
    chk("mid_gnt", io_gnt, 1);
    #1 reset = 0;
    #1;
    chk("mid_rst_gnt", io_gnt, 0);
    chk("mid_rst_stall", cpu_stall, 0);
    chk("mid_rst_mem_cs", mem_cs, 0);
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    smp();
    chk("mid_rst_no_done", io_done, 0);
    nxt();
    reset = 1;
    push(cyc + 4, 32'h1234_5678);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) nxt();
      smp();
      chk("post_rst_gnt", io_gnt, (j == 3) ? 1 : 0);
    end
    nxt(); idle();
    smp();
    smp();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-ported Data Memory between the CPU's data port and a second bus master (the I/O DMA requester). Sits between `CPU` (Addr, D_OUT, dm_cs/dm_rd/dm_wr) and the Data Memory module. The CPU is favoured, and a saturating starvation counter guarantees the DMA side a slot. The CPU is held off with a combinational stall that the MCU honours by repeating its current state.

## Interface
- `STARVE_LIMIT`, 3: number of cycles a pending DMA request may lose to the CPU before it is forced through. Range 0..15; 0 gives DMA strict priority.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_cs`, `cpu_rd`, `cpu_wr`  in  1 each  CPU data-memory flags (from CPU dm_cs/dm_rd/dm_wr).
- `cpu_addr`  in  32  CPU address (CPU Addr).
- `cpu_wdata`  in  32  CPU write data (CPU D_OUT).
- `cpu_rdata`  out  32  read data to the CPU (CPU D_MemToInt).
- `cpu_stall`  out  1  CPU access not performed this cycle; the MCU must hold all CPU flags, address and data.
- `io_req`  in  1  DMA request; held high with `io_wr`, `io_addr` and `io_wdata` stable until `io_done`.
- `io_wr`  in  1  1 = write, 0 = read.
- `io_addr`, `io_wdata`  in  32 each  DMA address and write data.
- `io_gnt`  out  1  DMA owns the memory this cycle (combinational).
- `io_done`  out  1  registered one-cycle completion pulse.
- `io_rdata`  out  32  registered DMA read data; valid while `io_done` = 1.
- `mem_cs`, `mem_rd`, `mem_wr`  out  1 each  Data Memory flags.
- `mem_addr`, `mem_wdata`  out  32 each  Data Memory address and write data.
- `mem_rdata`  in  32  Data Memory read data; combinational, valid in the same cycle as `mem_cs` & `mem_rd`.

## Operation
- **Registers:** `starve_cnt` (4 bits), `io_done`, `io_rdata`. Everything else is combinational.
- **`io_live`:** equals `io_req & ~io_done`. `io_req` is ignored during the done cycle, so each DMA access costs at least 2 cycles.
- **Grant:** `io_gnt` = `io_live & (~cpu_cs | starve_cnt == STARVE_LIMIT)`. The CPU owns the memory otherwise.
- **Stall:** `cpu_stall` = `cpu_cs & io_gnt`.
- **Mux when `io_gnt` = 1:**
  - `mem_cs` = 1, `mem_rd` = `~io_wr`, `mem_wr` = `io_wr`.
  - `mem_addr` = `io_addr`, `mem_wdata` = `io_wdata`.
- **Mux otherwise:** `mem_*` mirror the `cpu_*` signals unchanged, including the illegal combination `cpu_rd` & `cpu_wr`, which is passed through and not checked.
- **Read data:**
  - `cpu_rdata` = `mem_rdata` when the CPU owns the memory.
  - `cpu_rdata` = 32'h0 while `cpu_stall` = 1.
- **`starve_cnt`:**
  - Cleared on any cycle with `io_gnt` = 1.
  - Incremented, saturating at `STARVE_LIMIT`, on a cycle with `io_live` & `cpu_cs` & ~`io_gnt`.
  - Held otherwise, including the cycle with `io_live` = 0.
- **Completion:** on an edge ending a cycle with `io_gnt` = 1, set `io_done` <= 1. On a read (`io_wr` = 0) also capture `io_rdata` <= `mem_rdata`; on a write, `io_rdata` holds its previous value.
- **Pulse width:** `io_done` is forced to 0 on the next edge, so it is always exactly one cycle wide.
- **Write commit:** a write is committed by the Data Memory on the edge ending its grant cycle.

## Timing
- **Reset:** while `reset` = 0, `starve_cnt` = 0, `io_done` = 0 and `io_rdata` = 0. All `mem_*` outputs, `io_gnt` and `cpu_stall` are forced to 0 regardless of inputs.
  - Reset mid-access aborts a granted DMA access with no `io_done`.
  - Release of reset is effective at the next rising edge.
- **DMA latency:** request at cycle t with the CPU idle gives the grant at t and `io_done` at t+1.
- **Under CPU contention:** with `cpu_cs` continuously high, the grant comes at t+`STARVE_LIMIT` and `io_done` one cycle after it.
- **CPU latency:** zero when unstalled. A stalled CPU proceeds on the cycle after the DMA grant, which is the `io_done` cycle.
- **Back-to-back DMA:** keeping `io_req` high through `io_done` starts a new request at `io_done`+1. `starve_cnt` is 0 at that point.
- **`STARVE_LIMIT` = 0:** a live DMA request always wins, and the CPU stalls for one cycle per DMA access.

## Test plan
- **Reset:** assert `reset` = 0 mid DMA grant with `cpu_cs` = 1. Expect all outputs 0 at once, no `io_done`, and `starve_cnt` = 0 after release.
- **CPU only:** CPU write 32'hDEADBEEF to 0x10, then read 0x10. Expect `cpu_stall` = 0 throughout and `cpu_rdata` = 32'hDEADBEEF in the read cycle.
- **DMA only:** DMA read of 0x20 (holding 32'h12345678) at cycle 5. Expect `io_gnt` = 1 at cycle 5, and `io_done` = 1 with `io_rdata` = 32'h12345678 at cycle 6.
- **Starvation:** `STARVE_LIMIT` = 3, `cpu_cs` held high, `io_req` raised at cycle 0. Expect `io_gnt` and `cpu_stall` high at cycle 3 only, `io_done` at 4, and CPU access resumes at 4.
- **Simultaneous requests, limit 0:** `STARVE_LIMIT` = 0 with CPU and DMA both writing at cycle 0 (CPU 0x40 = 1, DMA 0x44 = 2). Expect the DMA write at cycle 0, the CPU write at cycle 1, and both locations correct afterwards.
- **Back-to-back DMA:** `io_req` held high for 3 reads. Expect `io_gnt` at cycles 0, 2, 4 and `io_done` at 1, 3, 5, never two consecutive grants.
